// File: rtl/hpu_regs_pkg.sv
// Register map, CTRL/STATUS layout, AXI-Lite response codes and FSM state type
// shared by the control-register block and its AXI-Lite handshake FSM.
package hpu_regs_pkg;

  localparam int WORD_CTRL    = 0;
  localparam int WORD_STATUS  = 1;
  localparam int WORD_CYCLES  = 2;
  localparam int WORD_VERSION = 3;
  localparam int WORD_CFG0    = 4;

  localparam int CTRL_MATW  = 0;
  localparam int CTRL_RUN   = 1;
  localparam int CTRL_LAST  = 2;
  localparam int CTRL_START = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_INI,
    ST_AW,
    ST_W,
    ST_AWW,
    ST_AR1,
    ST_AR2
  } axil_state_e;

  typedef struct packed {
    logic last;
    logic run;
    logic matw;
  } ctrl_t;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        done;
    logic        busy;
  } status_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_slave_fsm.sv
// AXI-Lite slave handshake: latches AW/W/AR, commits a write once in the first
// AWW cycle, strobes the read in AR1; one transaction in flight, B/R wait on ready.
module axil_slave_fsm
  import hpu_regs_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_strobe
);

  axil_state_e state_q, state_d;
  logic        committed_q;
  logic        aw_acc, w_acc, ar_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INI;
      committed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      committed_q <= (state_q == ST_AWW);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INI: begin
        if (s_axi_awvalid && s_axi_wvalid) state_d = ST_AWW;
        else if (s_axi_awvalid)            state_d = ST_AW;
        else if (s_axi_wvalid)             state_d = ST_W;
        else if (s_axi_arvalid)            state_d = ST_AR1;
      end
      ST_AW:   if (s_axi_wvalid)  state_d = ST_AWW;
      ST_W:    if (s_axi_awvalid) state_d = ST_AWW;
      ST_AWW:  if (s_axi_bready)  state_d = ST_INI;
      ST_AR1:  state_d = ST_AR2;
      ST_AR2:  if (s_axi_rready)  state_d = ST_INI;
      default: state_d = ST_INI;
    endcase
  end

  // Reset presents the idle handshake but the state register ignores inputs.
  assign s_axi_awready = rst || (state_q == ST_INI) || (state_q == ST_W);
  assign s_axi_wready  = rst || (state_q == ST_INI) || (state_q == ST_AW);
  assign s_axi_arready = rst || (state_q == ST_INI);
  assign s_axi_bvalid  = !rst && (state_q == ST_AWW);
  assign s_axi_rvalid  = !rst && (state_q == ST_AR2);
  assign wr_commit     = !rst && (state_q == ST_AWW) && !committed_q;
  assign rd_strobe     = !rst && (state_q == ST_AR1);

  assign aw_acc = s_axi_awvalid && ((state_q == ST_INI) || (state_q == ST_W));
  assign w_acc  = s_axi_wvalid  && ((state_q == ST_INI) || (state_q == ST_AW));
  assign ar_acc = s_axi_arvalid && (state_q == ST_INI) && !s_axi_awvalid && !s_axi_wvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      rd_addr <= '0;
    end else begin
      if (aw_acc) wr_addr <= s_axi_awaddr;
      if (w_acc) begin
        wr_data <= s_axi_wdata;
        wr_strb <= s_axi_wstrb;
      end
      if (ar_acc) rd_addr <= s_axi_araddr;
    end
  end

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite control/status register block: writes land one edge after commit,
// read data registered in AR1 and held through AR2; B/R held until ready.
module axil_ctrl_regs
  import hpu_regs_pkg::*;
#(
  parameter int          NUM_CFG = 8,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  ctrl_matw,
  output logic                  ctrl_run,
  output logic                  ctrl_last,
  output logic                  ctrl_start,
  output logic [32*NUM_CFG-1:0] cfg_q,
  input  logic                  stat_busy,
  input  logic                  stat_done_set
);

  logic              wr_commit, rd_strobe;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

  axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_commit     (wr_commit),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .rd_addr       (rd_addr),
    .rd_strobe     (rd_strobe)
  );

  logic [ADDR_W-3:0] wr_word, rd_word;
  logic [31:0]       wr_idx, rd_idx;
  logic              wr_mapped, rd_mapped;
  logic              unused_addr_lsbs;

  assign wr_word   = wr_addr[ADDR_W-1:2];
  assign rd_word   = rd_addr[ADDR_W-1:2];
  assign wr_idx    = 32'(wr_word);
  assign rd_idx    = 32'(rd_word);
  assign wr_mapped = wr_idx < 32'(WORD_CFG0 + NUM_CFG);
  assign rd_mapped = rd_idx < 32'(WORD_CFG0 + NUM_CFG);
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  // Latched write address is stable for the whole AWW phase.
  assign s_axi_bresp = wr_mapped ? RESP_OKAY : RESP_SLVERR;

  ctrl_t       ctrl_q;
  logic        start_q, done_q;
  logic [31:0] cycles_q;
  logic [31:0] cfg_r [NUM_CFG];
  logic        wr_ctrl, wr_status, wr_cycles;

  assign wr_ctrl   = wr_commit && (wr_idx == 32'(WORD_CTRL));
  assign wr_status = wr_commit && (wr_idx == 32'(WORD_STATUS));
  assign wr_cycles = wr_commit && (wr_idx == 32'(WORD_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (wr_ctrl && wr_strb[0]) begin
        ctrl_q.matw <= wr_data[CTRL_MATW];
        ctrl_q.run  <= wr_data[CTRL_RUN];
        ctrl_q.last <= wr_data[CTRL_LAST];
        start_q     <= wr_data[CTRL_START];
      end
      // A datapath set beats a simultaneous clear.
      if (stat_done_set)
        done_q <= 1'b1;
      else if (wr_status && wr_strb[0] && wr_data[STAT_DONE])
        done_q <= 1'b0;
      if (wr_cycles)
        cycles_q <= '0;
      else if (ctrl_q.run)
        cycles_q <= cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CFG; i++) begin
      if (rst)
        cfg_r[i] <= '0;
      else if (wr_commit && (wr_idx == 32'(WORD_CFG0 + i)))
        cfg_r[i] <= apply_strb(cfg_r[i], wr_data, wr_strb);
    end
  end

  logic [31:0] rd_val;
  logic [1:0]  rd_resp;
  status_t     status_w;

  always_comb begin
    status_w      = '0;
    status_w.busy = stat_busy;
    status_w.done = done_q;
    rd_val        = '0;
    rd_resp       = rd_mapped ? RESP_OKAY : RESP_SLVERR;
    if (rd_idx == 32'(WORD_CTRL))         rd_val = {29'd0, ctrl_q};
    else if (rd_idx == 32'(WORD_STATUS))  rd_val = status_w;
    else if (rd_idx == 32'(WORD_CYCLES))  rd_val = cycles_q;
    else if (rd_idx == 32'(WORD_VERSION)) rd_val = VERSION;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (rd_idx == 32'(WORD_CFG0 + i)) rd_val = cfg_r[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (rd_strobe) begin
      s_axi_rdata <= rd_val;
      s_axi_rresp <= rd_resp;
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg_q[32*g +: 32] = cfg_r[g];
  end

  assign ctrl_matw  = ctrl_q.matw;
  assign ctrl_run   = ctrl_q.run;
  assign ctrl_last  = ctrl_q.last;
  assign ctrl_start = start_q;

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs: AXI-Lite write/read tasks, hand-computed
// expected register values, one check task feeding the summary counters.
module tb_axil_ctrl_regs;

  localparam int NUM_CFG = 8;
  localparam int ADDR_W  = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_W-1:0]     s_axi_awaddr, s_axi_araddr;
  logic                  s_axi_awvalid, s_axi_awready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid, s_axi_wready;
  logic [1:0]            s_axi_bresp, s_axi_rresp;
  logic                  s_axi_bvalid, s_axi_bready;
  logic                  s_axi_arvalid, s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic                  s_axi_rvalid, s_axi_rready;
  logic                  ctrl_matw, ctrl_run, ctrl_last, ctrl_start;
  logic [32*NUM_CFG-1:0] cfg_q;
  logic                  stat_busy, stat_done_set;

  always #5 clk = ~clk;

  axil_ctrl_regs #(.NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W), .VERSION(32'h0001_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .ctrl_matw     (ctrl_matw),
    .ctrl_run      (ctrl_run),
    .ctrl_last     (ctrl_last),
    .ctrl_start    (ctrl_start),
    .cfg_q         (cfg_q),
    .stat_busy     (stat_busy),
    .stat_done_set (stat_done_set)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always @(negedge clk) if (ctrl_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int w_lag, input int b_lag,
                        output logic [1:0] resp);
    int n;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = (w_lag == 0);
    n = 0;
    while (!s_axi_awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("aw_ready", s_axi_awready, 1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    if (w_lag != 0) begin
      repeat (w_lag) @(posedge clk);
      #1;
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 20) begin @(posedge clk); #1; n++; end
      chk("w_ready", s_axi_wready, 1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bvalid", s_axi_bvalid, 1);
    for (int i = 0; i < b_lag; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", s_axi_bvalid, 1);
    end
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [ADDR_W-1:0] addr, input int r_lag,
                        output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ar_ready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rvalid", s_axi_rvalid, 1);
    for (int i = 0; i < r_lag; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", s_axi_rvalid, 1);
    end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          sbase;

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; stat_busy = 1'b0; stat_done_set = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_axi_awready, 1);
    chk("rst_wready",  s_axi_wready, 1);
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_bvalid",  s_axi_bvalid, 0);
    chk("rst_rvalid",  s_axi_rvalid, 0);
    rst = 1'b0;
    chk("rst_ctrl", {28'd0, ctrl_matw, ctrl_run, ctrl_last, ctrl_start}, 0);
    chk("rst_cfg_zero", (cfg_q == '0), 1);
    chk("rst_rdata", s_axi_rdata, 0);

    // Simultaneous AW+W to CTRL: run + start
    sbase = start_cnt;
    axi_wr(12'h000, 32'h0000_000A, 4'hF, 0, 0, resp);
    chk("s1_bresp", resp, 2'b00);
    chk("s1_run", ctrl_run, 1);
    chk("s1_matw", ctrl_matw, 0);
    chk("s1_start_now", ctrl_start, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("s1_start_cycles", start_cnt - sbase, 1);
    axi_rd(12'h000, 0, rd, resp);
    chk("s1_ctrl_rd", rd, 32'h2);
    chk("s1_ctrl_rresp", resp, 2'b00);

    // CTRL byte strobe: byte 0 disabled leaves CTRL untouched, no start
    sbase = start_cnt;
    axi_wr(12'h000, 32'h0000_000D, 4'hE, 0, 0, resp);
    chk("ctrl_nostrb", {29'd0, ctrl_last, ctrl_run, ctrl_matw}, 32'h2);
    axi_wr(12'h000, 32'h0000_0005, 4'h1, 0, 0, resp);
    chk("ctrl_strb0", {29'd0, ctrl_last, ctrl_run, ctrl_matw}, 32'h5);
    chk("ctrl_nostart", start_cnt - sbase, 0);
    axi_wr(12'h000, 32'h0000_0000, 4'hF, 0, 0, resp);

    // AW first, W three cycles later, bready stalled
    axi_wr(12'h010, 32'hAABB_CCDD, 4'h5, 3, 4, resp);
    chk("s2_bresp", resp, 2'b00);
    chk("s2_cfg0", cfg_q[31:0], 32'h00BB_00DD);
    axi_rd(12'h010, 0, rd, resp);
    chk("s2_cfg0_rd", rd, 32'h00BB_00DD);
    axi_wr(12'h02C, 32'h1234_5678, 4'hF, 0, 0, resp);
    chk("cfg7_bresp", resp, 2'b00);
    chk("cfg7", cfg_q[255:224], 32'h1234_5678);

    // Unmapped word just past the last cfg register
    axi_rd(12'h030, 1, rd, resp);
    chk("s3_rresp", resp, 2'b10);
    chk("s3_rdata", rd, 32'h0);
    axi_wr(12'h030, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    chk("s3_bresp", resp, 2'b10);
    chk("s3_cfg0", cfg_q[31:0], 32'h00BB_00DD);
    chk("s3_cfg7", cfg_q[255:224], 32'h1234_5678);
    chk("s3_ctrl", {29'd0, ctrl_last, ctrl_run, ctrl_matw}, 32'h0);

    // Sticky done: set alone, then set colliding with clear, then clear alone
    stat_done_set = 1'b1;
    @(posedge clk); #1;
    stat_done_set = 1'b0;
    axi_rd(12'h004, 0, rd, resp);
    chk("s4_done_set", rd, 32'h2);
    fork
      axi_wr(12'h004, 32'h0000_0002, 4'hF, 0, 0, resp);
      begin
        @(posedge clk); #1;
        stat_done_set = 1'b1;
        @(posedge clk); #1;
        stat_done_set = 1'b0;
      end
    join
    axi_rd(12'h004, 0, rd, resp);
    chk("s4_set_wins", rd, 32'h2);
    axi_wr(12'h004, 32'h0000_0003, 4'hF, 0, 0, resp);
    chk("s4_clr_bresp", resp, 2'b00);
    axi_rd(12'h004, 0, rd, resp);
    chk("s4_cleared", rd, 32'h0);
    stat_busy = 1'b1;
    axi_rd(12'h004, 0, rd, resp);
    chk("s4_busy", rd, 32'h1);
    stat_busy = 1'b0;

    // CYCLES: clear, run for exactly 100 counting edges, stop, clear again
    axi_wr(12'h008, 32'h0000_1234, 4'hF, 0, 0, resp);
    axi_rd(12'h008, 0, rd, resp);
    chk("s5_cleared0", rd, 32'h0);
    axi_wr(12'h000, 32'h0000_0002, 4'hF, 0, 0, resp);
    repeat (98) @(posedge clk);
    #1;
    axi_wr(12'h000, 32'h0000_0000, 4'hF, 0, 0, resp);
    axi_rd(12'h008, 0, rd, resp);
    chk("s5_cycles", rd, 32'd100);
    axi_wr(12'h008, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    chk("s5_clr_bresp", resp, 2'b00);
    axi_rd(12'h008, 0, rd, resp);
    chk("s5_cycles_clr", rd, 32'h0);

    // VERSION is read-only
    axi_wr(12'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    chk("ver_wr_bresp", resp, 2'b00);
    axi_rd(12'h00C, 0, rd, resp);
    chk("ver_rd", rd, 32'h0001_0000);

    // Reset while waiting for W in the AW state
    s_axi_awaddr  = 12'h014;
    s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    chk("s6_aw_awready", s_axi_awready, 0);
    rst = 1'b1;
    #1;
    chk("s6_rst_awready", s_axi_awready, 1);
    chk("s6_rst_bvalid", s_axi_bvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s6_ini_awready", s_axi_awready, 1);
    chk("s6_ini_wready", s_axi_wready, 1);
    chk("s6_ini_arready", s_axi_arready, 1);
    chk("s6_rdata_rst", s_axi_rdata, 0);
    chk("s6_cfg_zero", (cfg_q == '0), 1);
    axi_rd(12'h00C, 2, rd, resp);
    chk("s6_version", rd, 32'h0001_0000);
    chk("s6_rresp", resp, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
